conv_ifmap_addr_gen: RTL and testbench

Parametrised input-feature-map address generator for the convolution kernel datapath. For each output pixel it walks the K×K window of every input channel and emits one linear feature-map address per handshake. Output pixels are visited row-major with a configurable stride. It sits between the conv controller (start/abort/cfg) and the ifmap buffer read port, and replaces the fixed 64×64 / 4×4 / 8-channel generator with valid/ready flow control, framing flags and completion signalling.

---
 rtl/conv_ifmap_addr_gen.sv | 166 ++++++++++++++++
 tb/tb_conv_ifmap_addr_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ifmap_addr_gen.sv
// Input-feature-map address generator: walks the KxK window of every channel for each
// output pixel (row-major, strided) and emits one linear address per valid/ready handshake.
module conv_ifmap_addr_gen #(
   parameter int unsigned IMG_W    = 64,
   parameter int unsigned IMG_H    = 64,
   parameter int unsigned K        = 4,
   parameter int unsigned STRIDE   = 1,
   parameter int unsigned CH_GROUP = 8,
   parameter int unsigned ADDR_W   = 26
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [1:0]        cfg_ci_i,
   output logic              addr_valid_o,
   input  logic              addr_ready_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              win_last_o,
   output logic              pix_last_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned OUT_W = (IMG_W - K) / STRIDE + 1;
   localparam int unsigned OUT_H = (IMG_H - K) / STRIDE + 1;
   localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned CW    = $clog2(4 * CH_GROUP);
   localparam int unsigned OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int unsigned OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

   localparam logic [KW-1:0]     KLast    = KW'(K - 1);
   localparam logic [OXW-1:0]    OxLast   = OXW'(OUT_W - 1);
   localparam logic [OYW-1:0]    OyLast   = OYW'(OUT_H - 1);
   localparam logic [ADDR_W-1:0] RowInc   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] PlaneInc = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] PixInc   = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] LineInc  = ADDR_W'(STRIDE * IMG_W);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q;
   logic [KW-1:0]     kx_q, ky_q;
   logic [CW-1:0]     c_q, c_last_q;
   logic [OXW-1:0]    ox_q;
   logic [OYW-1:0]    oy_q;
   // Base addresses of the current output row, pixel, channel plane and window row.
   logic [ADDR_W-1:0] line_q, pix_q, chan_q, row_q, addr_q;

   logic run, kx_end, ky_end, c_end, ox_end, oy_end;

   assign run    = (state_q == StRun);
   assign kx_end = (kx_q == KLast);
   assign ky_end = (ky_q == KLast);
   assign c_end  = (c_q == c_last_q);
   assign ox_end = (ox_q == OxLast);
   assign oy_end = (oy_q == OyLast);

   assign addr_valid_o = run;
   assign busy_o       = run;
   assign done_o       = (state_q == StDone);
   assign addr_o       = addr_q;
   assign win_last_o   = run & kx_end & ky_end;
   assign pix_last_o   = win_last_o & c_end;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         kx_q     <= '0;
         ky_q     <= '0;
         c_q      <= '0;
         c_last_q <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         line_q   <= '0;
         pix_q    <= '0;
         chan_q   <= '0;
         row_q    <= '0;
         addr_q   <= '0;
      end else if (abort_i) begin
         state_q <= StIdle;
         kx_q    <= '0;
         ky_q    <= '0;
         c_q     <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         line_q  <= '0;
         pix_q   <= '0;
         chan_q  <= '0;
         row_q   <= '0;
         addr_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q  <= StRun;
                  kx_q     <= '0;
                  ky_q     <= '0;
                  c_q      <= '0;
                  ox_q     <= '0;
                  oy_q     <= '0;
                  line_q   <= '0;
                  pix_q    <= '0;
                  chan_q   <= '0;
                  row_q    <= '0;
                  addr_q   <= '0;
                  c_last_q <= CW'((32'(cfg_ci_i) + 32'd1) * CH_GROUP - 32'd1);
               end
            end
            StRun: begin
               if (addr_ready_i) begin
                  if (!kx_end) begin
                     kx_q   <= kx_q + 1'b1;
                     addr_q <= addr_q + 1'b1;
                  end else begin
                     kx_q <= '0;
                     if (!ky_end) begin
                        ky_q   <= ky_q + 1'b1;
                        row_q  <= row_q + RowInc;
                        addr_q <= row_q + RowInc;
                     end else begin
                        ky_q <= '0;
                        if (!c_end) begin
                           c_q    <= c_q + 1'b1;
                           chan_q <= chan_q + PlaneInc;
                           row_q  <= chan_q + PlaneInc;
                           addr_q <= chan_q + PlaneInc;
                        end else begin
                           c_q <= '0;
                           if (!ox_end) begin
                              ox_q   <= ox_q + 1'b1;
                              pix_q  <= pix_q + PixInc;
                              chan_q <= pix_q + PixInc;
                              row_q  <= pix_q + PixInc;
                              addr_q <= pix_q + PixInc;
                           end else begin
                              ox_q <= '0;
                              if (!oy_end) begin
                                 oy_q   <= oy_q + 1'b1;
                                 line_q <= line_q + LineInc;
                                 pix_q  <= line_q + LineInc;
                                 chan_q <= line_q + LineInc;
                                 row_q  <= line_q + LineInc;
                                 addr_q <= line_q + LineInc;
                              end else begin
                                 oy_q    <= '0;
                                 state_q <= StDone;
                                 line_q  <= '0;
                                 pix_q   <= '0;
                                 chan_q  <= '0;
                                 row_q   <= '0;
                                 addr_q  <= '0;
                              end
                           end
                        end
                     end
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_ifmap_addr_gen.sv
// Scoreboard bench for conv_ifmap_addr_gen on an 8x6 / K=3 / stride-2 / 2-channel-group config.
module tb_conv_ifmap_addr_gen;

   localparam int IW = 8;
   localparam int IH = 6;
   localparam int KK = 3;
   localparam int ST = 2;
   localparam int CG = 2;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, addr_ready;
   logic [1:0]    cfg_ci;
   logic          addr_valid, win_last, pix_last, busy, done;
   logic [AW-1:0] addr;

   always #5 clk = ~clk;

   conv_ifmap_addr_gen #(
      .IMG_W(IW), .IMG_H(IH), .K(KK), .STRIDE(ST), .CH_GROUP(CG), .ADDR_W(AW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .cfg_ci_i(cfg_ci),
      .addr_valid_o(addr_valid), .addr_ready_i(addr_ready), .addr_o(addr),
      .win_last_o(win_last), .pix_last_o(pix_last), .busy_o(busy), .done_o(done)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic          wl;
      logic          pl;
   } exp_t;

   exp_t          exp_q[$];
   int            seen[$];
   int            total = 0;
   int            bad = 0;
   int            hs_cnt = 0;
   int            done_cnt = 0;
   exp_t          mon_e;
   logic          stall_q = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic          prev_wl = 1'b0, prev_pl = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Reference sweep straight from the address formula.
   task automatic push_pass(input int ci);
      int   c_n, a;
      exp_t e;
      c_n = (ci + 1) * CG;
      for (int oy = 0; oy < (IH - KK) / ST + 1; oy++)
         for (int ox = 0; ox < (IW - KK) / ST + 1; ox++)
            for (int c = 0; c < c_n; c++)
               for (int ky = 0; ky < KK; ky++)
                  for (int kx = 0; kx < KK; kx++) begin
                     a    = c * IW * IH + (oy * ST + ky) * IW + ox * ST + kx;
                     e.a  = a[AW-1:0];
                     e.wl = (ky == KK - 1) && (kx == KK - 1);
                     e.pl = e.wl && (c == c_n - 1);
                     exp_q.push_back(e);
                  end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stall stability.
   always @(negedge clk) begin
      if (addr_valid && stall_q) begin
         chk("stall_addr", int'(addr), int'(prev_addr));
         chk("stall_win_last", int'(win_last), int'(prev_wl));
         chk("stall_pix_last", int'(pix_last), int'(prev_pl));
      end
      if (addr_valid && addr_ready) begin
         hs_cnt++;
         seen.push_back(int'(addr));
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_addr: got %0d, required no handshake", addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("addr", int'(addr), int'(mon_e.a));
            chk("win_last", int'(win_last), int'(mon_e.wl));
            chk("pix_last", int'(pix_last), int'(mon_e.pl));
         end
      end
      if (done) done_cnt++;
      stall_q   <= addr_valid && !addr_ready;
      prev_addr <= addr;
      prev_wl   <= win_last;
      prev_pl   <= pix_last;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Waits for the DONE cycle, then checks the pass length and DONE-cycle outputs.
   task automatic wait_done(input int n, input int base, input string name, input bit rnd);
      int cyc = 0;
      while (!done && cyc < 5000) begin
         if (rnd) addr_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      addr_ready = 1'b1;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done, required done within 5000 cycles", name);
      end else begin
         chk({name, "_len"}, hs_cnt - base, n);
         chk({name, "_sb_empty"}, exp_q.size(), 0);
         chk({name, "_done_valid"}, int'(addr_valid), 0);
         chk({name, "_done_busy"}, int'(busy), 0);
      end
   endtask

   task automatic wait_hs(input int n, input int base);
      int cyc = 0;
      while (hs_cnt - base < n && cyc < 1000) begin
         tick();
         cyc++;
      end
      chk("hs_reached", hs_cnt - base, n);
   endtask

   int base, sb, dc;
   int hand_first[18] = '{0, 1, 2, 8, 9, 10, 16, 17, 18, 48, 49, 50, 56, 57, 58, 64, 65, 66};

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_ci = 2'd0; addr_ready = 1'b1;
      repeat (3) tick();
      chk("rst_valid", int'(addr_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_win_last", int'(win_last), 0);
      chk("rst_pix_last", int'(pix_last), 0);
      rst_n = 1'b1;
      tick();

      // start and abort together in IDLE stay in IDLE
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", int'(addr_valid), 0);

      // Pass 1: cfg_ci=0, ready=1, hand-checked addresses
      push_pass(0);
      base = hs_cnt; sb = seen.size();
      do_start();
      chk("start_valid", int'(addr_valid), 1);
      chk("start_busy", int'(busy), 1);
      chk("start_addr", int'(addr), 0);
      wait_done(108, base, "pass1", 1'b0);
      tick();
      chk("done_width", int'(done), 0);
      for (int i = 0; i < 18; i++) chk("hand_window", seen[sb + i], hand_first[i]);
      chk("hand_next_pixel", seen[sb + 18], 2);
      chk("hand_row_wrap", seen[sb + 54], 16);
      chk("hand_last", seen[sb + 107], 86);

      // Pass 2: cfg_ci=3 (C=8) with random ready
      cfg_ci = 2'd3;
      push_pass(3);
      base = hs_cnt;
      do_start();
      wait_done(432, base, "pass_rand", 1'b1);
      tick();

      // Abort after the 20th handshake, then restart
      cfg_ci = 2'd0;
      push_pass(0);
      base = hs_cnt; dc = done_cnt;
      do_start();
      wait_hs(20, base);
      addr_ready = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", int'(addr_valid), 0);
      chk("abort_busy", int'(busy), 0);
      repeat (3) tick();
      chk("abort_no_done", done_cnt, dc);
      chk("abort_stay_idle", int'(addr_valid), 0);
      exp_q.delete();
      addr_ready = 1'b1;
      push_pass(0);
      base = hs_cnt; sb = seen.size();
      do_start();
      wait_done(108, base, "pass_restart", 1'b0);
      chk("restart_first", seen[sb], 0);
      tick();

      // start/cfg_ci noise mid-RUN, start in DONE ignored, start in first IDLE accepted
      push_pass(0);
      base = hs_cnt;
      do_start();
      wait_hs(30, base);
      cfg_ci = 2'd3; start = 1'b1;
      tick();
      start = 1'b0; cfg_ci = 2'd1;
      wait_done(108, base, "pass_noise", 1'b0);
      start = 1'b1;
      tick();
      chk("done_start_ignored", int'(addr_valid), 0);
      chk("done_start_busy", int'(busy), 0);
      push_pass(1);
      base = hs_cnt;
      tick();
      start = 1'b0;
      chk("idle_start_valid", int'(addr_valid), 1);
      chk("idle_start_addr", int'(addr), 0);
      wait_done(216, base, "pass_c4", 1'b0);
      tick();

      // Asynchronous reset mid-pass drops the pass
      cfg_ci = 2'd0;
      push_pass(0);
      base = hs_cnt;
      do_start();
      wait_hs(10, base);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(addr_valid), 0);
      chk("midrst_addr", int'(addr), 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("midrst_no_restart", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before 2000000 time units");
      $fatal(1);
   end

endmodule
